// File: rtl/psp_mem_pkg.sv
// Shared types for the memory port B arbiter: FSM states, requester ids and the muxed request bundle.
package psp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    function automatic arb_state_e own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational 2-way picker: pointer priority when policy_rr is set, requester 0 priority otherwise.
module arb_pick (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    input  logic       policy_rr,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic prio;

    always_comb begin
        prio      = policy_rr ? rr_ptr : 1'b0;
        gnt_idx   = valid[prio] ? prio : ~prio;
        gnt_valid = |valid;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates BRAM port B between CPU (0) and DMA/loader (1) with optional locked bursts.
// Define PSP_ARB_RR_EN for round-robin idle arbitration; default build uses fixed CPU priority.
module mem_port_arbiter
    import psp_mem_pkg::*;
#(
    parameter  int MEM_SIZE  = 8192,
    parameter  int MAX_BURST = 8,
    localparam int ADDR_W    = $clog2(MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_lock,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][3:0]        req_be,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   mem_we,
    input  logic [31:0]            mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    arb_state_e       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             rr_ptr;
    logic             handoff_pend;
    logic             handoff_idx;

    logic             owner;
    logic             arb_idle;
    logic             pick_rr_ptr;
    logic             pick_policy;
    logic             pick_idx;
    logic             pick_valid;
    logic             gnt_idx;
    logic             gnt_on;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] new_cnt;
    logic             yield;
    mem_req_t         sel;

    // An owner that stops requesting loses the port immediately, so this cycle is arbitrated as idle.
    always_comb begin
        owner       = (state == OWN1);
        arb_idle    = (state == IDLE) || !req_valid[owner];
        pick_rr_ptr = handoff_pend ? handoff_idx : rr_ptr;
`ifdef PSP_ARB_RR_EN
        pick_policy = 1'b1;
`else
        pick_policy = handoff_pend;
`endif
    end

    arb_pick u_pick (
        .valid     (req_valid),
        .rr_ptr    (pick_rr_ptr),
        .policy_rr (pick_policy),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        gnt_idx   = arb_idle ? pick_idx : owner;
        gnt_on    = (arb_idle ? pick_valid : 1'b1) & rst_n;
        req_ready = gnt_on ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

        cnt_base  = arb_idle ? '0 : beat_cnt;
        new_cnt   = (cnt_base >= MAX_C) ? MAX_C : cnt_base + 1'b1;
        yield     = req_lock[gnt_idx] && (new_cnt == MAX_C) && req_valid[~gnt_idx];

        sel.we    = req_we[gnt_on ? gnt_idx : REQ_CPU];
        sel.addr  = 32'(req_addr[gnt_on ? gnt_idx : REQ_CPU]);
        sel.wdata = req_wdata[gnt_on ? gnt_idx : REQ_CPU];
        sel.be    = req_be[gnt_on ? gnt_idx : REQ_CPU];

        mem_addr  = ADDR_W'(sel.addr);
        mem_wdata = sel.wdata;
        mem_we    = gnt_on & sel.we;
        mem_be    = gnt_on ? sel.be : 4'b0000;
        rsp_rdata = mem_rdata;
    end

    // A burst that hits MAX_BURST while the other side waits returns to IDLE and hands priority over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            rr_ptr       <= 1'b0;
            handoff_pend <= 1'b0;
            handoff_idx  <= 1'b0;
            rsp_valid    <= 2'b00;
        end else begin
            rsp_valid <= req_ready;
            if (gnt_on) begin
                if (arb_idle) begin
                    handoff_pend <= 1'b0;
`ifdef PSP_ARB_RR_EN
                    rr_ptr <= ~gnt_idx;
`endif
                end
                if (!req_lock[gnt_idx]) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else if (yield) begin
                    state        <= IDLE;
                    beat_cnt     <= '0;
                    handoff_pend <= 1'b1;
                    handoff_idx  <= ~gnt_idx;
                end else begin
                    state    <= own_state(gnt_idx);
                    beat_cnt <= new_cnt;
                end
            end else if (arb_idle && state != IDLE) begin
                state    <= IDLE;
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a 1-cycle read-before-write BRAM model.
// Honours PSP_ARB_RR_EN when computing expected grants.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int WORDS  = 2048;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_lock;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][31:0]       req_wdata;
    logic [1:0][3:0]        req_be;
    logic [1:0]             rsp_valid;
    logic [31:0]            rsp_rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_be;
    logic                   mem_we;
    logic [31:0]            mem_rdata;

    logic [31:0] fmem    [WORDS];
    logic [31:0] ref_mem [WORDS];

    typedef struct {
        logic [1:0]  vec;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter #(.MEM_SIZE(8192), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= fmem[mem_addr[ADDR_W-1:2]];
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) fmem[mem_addr[ADDR_W-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic valid, input logic lock, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be);
        req_valid[r] = valid;
        req_lock[r]  = lock;
        req_we[r]    = we;
        req_addr[r]  = addr;
        req_wdata[r] = wdata;
        req_be[r]    = be;
    endtask

    task automatic clearAll();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // One clock: check the grant, queue the expected response, then check what comes back.
    task automatic step(input logic [1:0] exp_ready, input string tag);
        exp_t e;
        int   idx;
        int   w;
        #1;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != 2'b00) begin
            idx = exp_ready[1] ? 1 : 0;
            w   = int'(req_addr[idx][ADDR_W-1:2]);
            checkOutput({tag, "_maddr"}, 32'(mem_addr), 32'(req_addr[idx]));
            checkOutput({tag, "_mwe"}, 32'(mem_we), 32'(req_we[idx]));
            e.vec  = exp_ready;
            e.data = ref_mem[w];
            sb.push_back(e);
            if (req_we[idx]) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[idx][b]) ref_mem[w][8*b +: 8] = req_wdata[idx][8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_rspv"}, 32'(rsp_valid), 32'(e.vec));
            checkOutput({tag, "_rdata"}, rsp_rdata, e.data);
        end else begin
            checkOutput({tag, "_rspv_idle"}, 32'(rsp_valid), 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            fmem[i]    = 32'h1234_0000 + i * 32'h0000_9E37;
            ref_mem[i] = 32'h1234_0000 + i * 32'h0000_9E37;
        end
        rst_n = 1'b0;
        clearAll();

        // Reset: a pending CPU write must not reach memory.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 13'h004, 32'hFFFF_FFFF, 4'hF);
        #2;
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_mwe", 32'(mem_we), 32'h0);
        checkOutput("rst_mbe", 32'(mem_be), 32'h0);
        checkOutput("rst_rspv", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_rspv2", 32'(rsp_valid), 32'h0);
        clearAll();
        rst_n = 1'b1;

        // No grant: memory enables low, address follows requester 0.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 13'h0AC, 32'h0, 4'hF);
        #1;
        checkOutput("nogrant_mbe", 32'(mem_be), 32'h0);
        checkOutput("nogrant_mwe", 32'(mem_we), 32'h0);
        checkOutput("nogrant_maddr", 32'(mem_addr), 32'h0AC);
        step(2'b00, "nogrant");

        applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h010, 32'h0, 4'hF);
        step(2'b01, "cpu_rd10");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 13'h008, 32'hAABB_CCDD, 4'b0010);
        #1;
        checkOutput("cpu_wr_mbe", 32'(mem_be), 32'h2);
        checkOutput("cpu_wr_mwdata", mem_wdata, 32'hAABB_CCDD);
        step(2'b01, "cpu_wr8");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h008, 32'h0, 4'hF);
        step(2'b01, "cpu_rd8");
        checkOutput("cpu_rd8_byte1", rsp_rdata, {fmem[2][31:16], 8'hCC, fmem[2][7:0]});

        // Both requesting from IDLE.
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 13'h040, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, ADDR_W'(13'h020 + 4 * i), 32'h0, 4'hF);
`ifdef PSP_ARB_RR_EN
            step((i % 2 == 0) ? 2'b10 : 2'b01, "both_rr");
`else
            step(2'b01, "both_fixed");
`endif
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(2'b10, "dma_next");
        clearAll();

        // DMA locked burst of 12 with the CPU waiting from beat 2.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, 1'b1, (k != 11), (k % 3 == 0), ADDR_W'(13'h200 + 4 * k),
                          32'hD000_0000 | k, 4'hF);
            if (k == 1) applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h030, 32'h0, 4'hF);
            if (k == 8) begin
                step(2'b01, "burst_cpu_slot");
                applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end
            step(2'b10, "burst_dma");
        end
        clearAll();
        step(2'b00, "burst_done");

        // Saturated counter: CPU arrives after 10 lone beats and gets the very next slot.
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1, 1'b1, 1'b1, 1'b0, ADDR_W'(13'h400 + 4 * k), 32'h0, 4'hF);
            if (k == 10) applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h034, 32'h0, 4'hF);
            step(2'b10, "sat_dma");
        end
        step(2'b01, "sat_cpu");
        clearAll();
        step(2'b00, "sat_done");

        // Owner drops valid for a cycle: CPU is served at once and the FSM is back in IDLE.
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 13'h500, 32'h0, 4'hF);
        step(2'b10, "drop_dma");
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 13'h504, 32'h0, 4'hF);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h038, 32'h0, 4'hF);
        step(2'b01, "drop_cpu");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 13'h504, 32'h0, 4'hF);
`ifdef PSP_ARB_RR_EN
        step(2'b10, "drop_idle");
`else
        step(2'b01, "drop_idle");
`endif
        clearAll();
        step(2'b00, "drop_done");

        // Reset in the middle of a DMA burst.
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 13'h600, 32'h0, 4'hF);
        step(2'b10, "mrst_beat1");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 13'h604, 32'h0, 4'hF);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 13'h03C, 32'h0, 4'hF);
        #1;
        checkOutput("mrst_own_ready", 32'(req_ready), 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_ready", 32'(req_ready), 32'h0);
        checkOutput("mrst_rspv", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mrst_rspv2", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        step(2'b01, "mrst_cpu_first");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(2'b10, "mrst_dma");
        clearAll();
        step(2'b00, "mrst_done");

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
